weight_pingpong_buffer: RTL
===========================

// Module: weight_pingpong_buffer
// PURPOSE
// - Double-banked (ping-pong) weight store feeding the systolic array's weight-load path.
// - Host/DMA fills one bank while the array reads LANES consecutive weights per cycle from the other.
// - Generalises the single-bank 4-wide weight memory: parametrised lanes/depth/width, write port, load/release handshake, read-valid.
// PARAMETERS
// - DATA_W  8   bits per weight
// - LANES   4   weights returned per read (array width)
// - DEPTH   32  words per bank; power of two, >= LANES
// - ADDR_W  $clog2(DEPTH)  derived, do not override
// PORTS
// - clk          in   1               clock
// - reset        in   1               asynchronous, active-high
// - wr_en        in   1               write one word into the fill bank
// - wr_addr      in   ADDR_W          fill-bank word address
// - wr_data      in   DATA_W          weight to write
// - wr_ready     out  1               fill bank accepting writes (not FULL)
// - load_done    in   1               pulse: fill bank contents complete
// - release_bank in   1               pulse: consumer finished with the active bank
// - active_valid out  1               active bank holds a complete weight set
// - rd_req       in   1               read request
// - rd_addr      in   ADDR_W          base address in the active bank
// - rd_valid     out  1               rd_data valid (1 cycle after an accepted rd_req)
// - rd_data      out  LANES*DATA_W    lane i = active[(rd_addr+i) mod DEPTH]; lane 0 in LSBs
// - rd_err       out  1               pulse: rd_req while no active bank
// BEHAVIOUR
// - Bank state per bank: EMPTY -> (load_done) FULL -> (selected) ACTIVE -> (release_bank) EMPTY.
// - Pointer act_sel selects the ACTIVE bank; fill bank = ~act_sel. Writes only ever target the fill bank.
// - Reset: both banks EMPTY, memory cleared to 0, act_sel=0.
// - Reset outputs: rd_data=0, rd_valid=0, rd_err=0, active_valid=0, wr_ready=1.
// - Reset asserted mid-load or mid-read aborts everything; nothing survives.
// - Write: wr_en && wr_ready writes mem[fill][wr_addr] at the clock edge.
// - Write while fill bank FULL is dropped; no state change.
// - load_done: fill bank EMPTY -> FULL. A wr_en in the same cycle is written first.
// - load_done while fill bank is already FULL is ignored.
// - Swap: at any edge where no bank is ACTIVE and the fill bank is FULL, the fill bank becomes ACTIVE.
//   - act_sel toggles; active_valid rises the next cycle; wr_ready follows the new fill bank (EMPTY -> 1).
// - release_bank: ACTIVE bank -> EMPTY.
//   - Same cycle as a FULL fill bank (including load_done in the same cycle): swap takes effect at the same edge, so active_valid stays 1 with no bubble.
//   - release_bank with no ACTIVE bank is ignored.
// - Read: rd_req && active_valid -> next cycle rd_valid=1 with rd_data from the bank active at the request edge.
//   - Addresses wrap modulo DEPTH.
//   - A release in the request cycle does not corrupt the in-flight data: data is registered at the request edge.
// - rd_req && !active_valid -> next cycle rd_err=1, rd_valid=0, rd_data holds its previous value.
// - Back-to-back rd_req each cycle gives one result per cycle; throughput 1, latency 1.
// - rd_data holds its last value when rd_valid=0.
// - Non-blocking assignments only in clocked logic; the read path is registered, never combinational.
// STRUCTURE
// - Shared package tpu_pkg: typedef bank_state_e {BANK_EMPTY, BANK_FULL, BANK_ACTIVE}; localparam WEIGHT_W=8.
// - One natural sub-module: weight_bank (DEPTH x DATA_W regfile, one write port, LANES-wide wrapped read port).
//   - Instantiated twice.
// - Top level holds the bank FSMs, act_sel, the read pipeline register and the error flag.
// TESTING
// - Reset, then rd_req addr 0 -> rd_err=1 next cycle, rd_valid=0; wr_ready=1, active_valid=0.
// - Write 0x01..0x20 to addr 0..31, load_done -> active_valid=1 two cycles later.
//   - rd_addr=4 -> rd_data lanes {0x05,0x06,0x07,0x08} after 1 cycle.
// - Wrap: rd_addr=30 -> lanes {0x1F,0x20,0x01,0x02}.
// - Ping-pong: with bank A active, fill B with 0xA0.., load_done; wr_ready=0.
//   - Extra write to B is dropped.
//   - release_bank -> next-cycle rd_addr=0 returns {0xA0,0xA1,0xA2,0xA3} and active_valid never drops.
// - Simultaneous: wr_en(addr 31, 0x77)+load_done same cycle, then release -> rd_addr=31 lane0=0x77.
// - Reset asserted mid-fill with one bank active -> all outputs to reset values; next rd_req gives rd_err.

Source files
------------

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared types and constants for the TPU weight path.
//            bank_state_e - lifecycle of one weight bank
//            WEIGHT_W     - default weight width in bits
// Revision : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int WEIGHT_W = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY  = 2'd0,
        BANK_FULL   = 2'd1,
        BANK_ACTIVE = 2'd2
    } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/weight_bank.sv
`default_nettype none
// ============================================================================
// Module   : weight_bank
// Purpose  : DEPTH x DATA_W register file, one write port and a LANES-wide
//            read port returning consecutive words with modulo-DEPTH wrap.
// Ports    : clk       - clock
//            rst       - asynchronous active-high reset, clears all words
//            i_wr_en   - write strobe
//            i_wr_addr - write word address
//            i_wr_data - write data
//            i_rd_addr - read base address
//            o_rd_data - LANES words, lane 0 in the LSBs (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module weight_bank #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [DATA_W-1:0]       i_wr_data,
    input  logic [ADDR_W-1:0]       i_rd_addr,
    output logic [LANES*DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so the ADDR_W-bit sum wraps modulo DEPTH.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
        logic [ADDR_W-1:0] w_idx;
        assign w_idx = i_rd_addr + ADDR_W'(gi);
        assign o_rd_data[gi*DATA_W +: DATA_W] = r_mem[w_idx];
    end

endmodule
`default_nettype wire

// File: rtl/weight_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : weight_pingpong_buffer
// Purpose  : Double-banked weight store. The host fills one bank while the
//            systolic array reads LANES consecutive weights per cycle from
//            the other; banks swap through a load/release handshake.
// Ports    : clk, reset (async, active-high)
//            wr_en/wr_addr/wr_data - write into the fill bank
//            wr_ready              - fill bank accepting writes
//            load_done             - fill bank complete
//            release_bank          - consumer done with active bank
//            active_valid          - active bank holds a complete set
//            rd_req/rd_addr        - read LANES words from active bank
//            rd_valid/rd_data      - registered read result, latency 1
//            rd_err                - read requested with no active bank
// Revision : 1.0 - initial release
// ============================================================================
module weight_pingpong_buffer
    import tpu_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W,
    parameter int LANES  = 4,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    input  logic                    load_done,
    input  logic                    release_bank,
    output logic                    active_valid,
    input  logic                    rd_req,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_valid,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_err
);

    logic                    r_act_sel;
    bank_state_e             r_state [2];
    logic                    r_rd_valid;
    logic                    r_rd_err;
    logic [LANES*DATA_W-1:0] r_rd_data;

    logic                    w_fill_sel;
    bank_state_e             w_act_state;
    bank_state_e             w_fill_state;
    logic                    w_active;
    logic                    w_fill_full;
    logic                    w_load_ok;
    logic                    w_release;
    logic                    w_swap;
    logic                    w_wr_ok;
    logic [LANES*DATA_W-1:0] w_bank_rd [2];

    assign w_fill_sel   = ~r_act_sel;
    assign w_act_state  = r_state[r_act_sel];
    assign w_fill_state = r_state[w_fill_sel];

    assign w_active     = (w_act_state == BANK_ACTIVE);
    assign w_fill_full  = (w_fill_state == BANK_FULL);
    assign w_load_ok    = load_done && (w_fill_state == BANK_EMPTY);
    assign w_release    = release_bank && w_active;

    // Idle swap waits for a registered FULL; a release swaps immediately,
    // also when the fill bank only becomes complete at this same edge, so
    // the array sees no gap in active_valid.
    assign w_swap = (w_fill_full && !w_active) ||
                    (w_release && (w_fill_full || w_load_ok));

    assign w_wr_ok = wr_en && wr_ready;

    for (genvar gb = 0; gb < 2; gb++) begin : g_banks
        logic w_we;
        assign w_we = w_wr_ok && (w_fill_sel == 1'(gb));

        weight_bank #(
            .DATA_W (DATA_W),
            .LANES  (LANES),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk       (clk),
            .rst       (reset),
            .i_wr_en   (w_we),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_addr (rd_addr),
            .o_rd_data (w_bank_rd[gb])
        );
    end

    // Bank lifecycle and active pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_act_sel  <= 1'b0;
        end else if (w_swap) begin
            r_state[w_fill_sel] <= BANK_ACTIVE;
            r_state[r_act_sel]  <= BANK_EMPTY;
            r_act_sel           <= w_fill_sel;
        end else begin
            if (w_release) begin
                r_state[r_act_sel] <= BANK_EMPTY;
            end
            if (w_load_ok) begin
                r_state[w_fill_sel] <= BANK_FULL;
            end
        end
    end

    // Read data is captured at the request edge, so a release or swap in
    // the same cycle cannot alter the result in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_req && w_active;
            r_rd_err   <= rd_req && !w_active;
            if (rd_req && w_active) begin
                r_rd_data <= w_bank_rd[r_act_sel];
            end
        end
    end

    assign wr_ready     = (w_fill_state == BANK_EMPTY);
    assign active_valid = w_active;
    assign rd_valid     = r_rd_valid;
    assign rd_err       = r_rd_err;
    assign rd_data      = r_rd_data;

endmodule
`default_nettype wire
